// File: rtl/mdu_iter_if.sv
// mdu_iter_if: handshake and HI/LO bus between the core controller and the
// iterative multiply/divide unit.
//   start/op/a/b   : launch request with operation and operands
//   hi_we/lo_we/wd : MTHI/MTLO write port
//   busy/done      : progress flag and one-cycle completion pulse
//   hi/lo          : architectural HI/LO registers
// master = controller side, slave = mdu_iter side.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO.
// One bit per cycle: WIDTH iterations in RUN, then one FIX cycle that applies
// sign correction and writes HI/LO. done pulses WIDTH+1 cycles after the
// start edge.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mdu_iter_if.slave (start/op/a/b, hi_we/lo_we/wd, busy/done, hi/lo)
// ops: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU.
// Optional feature macro MDU_MADD_EN enables MADD/MADDU; without it those
// ops are treated as illegal and a start carrying them is ignored.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    mdu_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_next;
    logic   accept, iterate, fix, mt_ok;

    // input decode
    logic             op_legal, in_div, in_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // latched operation context
    logic             is_div_q, b_zero_q, neg_q, rem_neg_q;
    logic [WIDTH-1:0] a_q, d_q;
`ifdef MDU_MADD_EN
    logic             madd_q;
`endif

    // iteration datapath
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH:0]   add_sum, rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // result
    logic [2*WIDTH-1:0] prod_mag, prod, res;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;

    always_comb begin
`ifdef MDU_MADD_EN
        op_legal = (bus.op <= 3'd5);
`else
        op_legal = (bus.op <= 3'd3);
`endif
    end

    assign in_div    = (bus.op[2:1] == 2'b01);
    assign in_signed = ~bus.op[0];
    assign a_neg     = in_signed & bus.a[WIDTH-1];
    assign b_neg     = in_signed & bus.b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        iterate    = 1'b0;
        fix        = 1'b0;
        mt_ok      = 1'b0;
        case (state)
            IDLE: begin
                mt_ok = 1'b1;
                if (bus.start && op_legal) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                iterate = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                fix        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- one iteration ----------------
    // Multiply: acc_lo holds the multiplier and shifts right while the partial
    // product enters from the top. Divide: acc_lo holds the dividend and
    // shifts left into the remainder while quotient bits enter from the bottom.
    always_comb begin
        add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? d_q : {WIDTH{1'b0}})};
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, d_q});
        // remainder after subtract is always < divisor, so WIDTH bits suffice
        diff    = rem_sh[WIDTH-1:0] - d_q;
        step_hi = add_sum[WIDTH:1];
        step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div_q) begin
            step_hi = ge ? diff : rem_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ge};
        end
    end

    // ---------------- sign fix / result select ----------------
    always_comb begin
        prod_mag = {acc_hi, acc_lo};
        prod     = neg_q ? -prod_mag : prod_mag;
        quot     = neg_q ? -acc_lo : acc_lo;
        rem      = rem_neg_q ? -acc_hi : acc_hi;
        res      = prod;
        if (is_div_q) begin
            // divide by zero: raw dividend to HI, all ones to LO, no sign fix
            res = b_zero_q ? {a_q, {WIDTH{1'b1}}} : {rem, quot};
        end
`ifdef MDU_MADD_EN
        else if (madd_q) begin
            // HI/LO as seen in FIX is the addend; wraps modulo 2^(2*WIDTH)
            res = {hi_reg, lo_reg} + prod;
        end
`endif
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            d_q       <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
`ifdef MDU_MADD_EN
            madd_q    <= 1'b0;
`endif
        end else if (accept) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= in_div ? a_mag : b_mag;
            d_q       <= in_div ? b_mag : a_mag;
            a_q       <= bus.a;
            is_div_q  <= in_div;
            b_zero_q  <= (bus.b == '0);
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
`ifdef MDU_MADD_EN
            madd_q    <= bus.op[2];
`endif
        end else if (iterate) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // HI/LO change only at reset, FIX, or MTHI/MTLO while idle. An MT write
    // on the start edge lands and is later overwritten by the op result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= fix;
            if (fix) begin
                hi_reg <= res[2*WIDTH-1:WIDTH];
                lo_reg <= res[WIDTH-1:0];
            end else if (mt_ok) begin
                if (bus.hi_we) hi_reg <= bus.wd;
                if (bus.lo_we) lo_reg <= bus.wd;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed scoreboard bench for mdu_iter (WIDTH=32).
// Stimulus pushes hand-computed {hi,lo} results into a queue; a monitor pops
// and compares whenever done is presented.
module tb_mdu_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) mif ();
    mdu_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(mif));

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] exp_q[$];
    string          name_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (mif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: hi=%h lo=%h with no operation pending", mif.hi, mif.lo);
            end else begin
                logic [2*W-1:0] e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {mif.hi, mif.lo}, e);
                check({n, "_busy_in_done"}, 64'(mif.busy), 64'd0);
            end
        end
    end

    task automatic idle_inputs();
        mif.start = 1'b0;
        mif.op    = 3'd1;
        mif.a     = '0;
        mif.b     = '0;
        mif.hi_we = 1'b0;
        mif.lo_we = 1'b0;
        mif.wd    = '0;
    endtask

    // mode 0: plain; 1: start+MTHI injected mid-RUN; 2: MTHI on start edge
    task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp, input int mode);
        int lat;
        int bcnt;
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        if (mode == 2) begin
            mif.hi_we = 1'b1;
            mif.wd    = 32'h77;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        mif.a = $urandom();
        mif.b = $urandom();
        if (mode == 2) check({nm, "_mthi_on_start"}, 64'(mif.hi), 64'h77);
        lat     = 0;
        bcnt    = 0;
        hold_hi = mif.hi;
        hold_lo = mif.lo;
        while (mif.done !== 1'b1 && lat < 100) begin
            if (mif.busy === 1'b1) bcnt++;
            if (mode == 1 && lat == 5) begin
                mif.start = 1'b1;
                mif.op    = 3'd1;
                mif.a     = 32'd9;
                mif.b     = 32'd9;
                mif.hi_we = 1'b1;
                mif.wd    = 32'h55;
            end
            if (mode == 1 && lat == 6) begin
                idle_inputs();
                check({nm, "_hi_hold_run"}, 64'(mif.hi), 64'(hold_hi));
                check({nm, "_lo_hold_run"}, 64'(mif.lo), 64'(hold_lo));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'd33);
        check({nm, "_busy_cycles"}, 64'(bcnt), 64'd32);
    endtask

    task automatic mt(input bit h, input bit l, input logic [W-1:0] d);
        @(negedge clk);
        mif.hi_we = h;
        mif.lo_we = l;
        mif.wd    = d;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic illegal_start(input string nm, input logic [2:0] op);
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        h0 = mif.hi;
        l0 = mif.lo;
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = 32'd3;
        mif.b     = 32'd3;
        @(posedge clk);
        #1;
        idle_inputs();
        check({nm, "_busy"}, 64'(mif.busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_busy_later"}, 64'(mif.busy), 64'd0);
        check({nm, "_hilo"}, {mif.hi, mif.lo}, {h0, l0});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", {mif.hi, mif.lo}, 64'd0);
        check("reset_busy_done", {62'd0, mif.busy, mif.done}, 64'd0);
        reset = 1'b0;

        // reset 10 cycles into a MULTU
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = 3'd1;
        mif.a     = 32'd1000;
        mif.b     = 32'd1000;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (9) @(posedge clk);
        #1;
        check("midrun_busy", 64'(mif.busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_hilo", {mif.hi, mif.lo}, 64'd0);
        check("abort_busy_done", {62'd0, mif.busy, mif.done}, 64'd0);

        run_op("multu_6x7", 3'd1, 32'd6, 32'd7, 64'd42, 0);
        run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
        run_op("divu_123_0", 3'd3, 32'd123, 32'd0, 64'h0000_007B_FFFF_FFFF, 0);
        run_op("div_m5_0", 3'd2, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 0);
        run_op("div_100_m7", 3'd2, 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 0);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0);
        run_op("mult_busy_inject", 3'd0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1);

        mt(1'b0, 1'b1, 32'hAA);
        check("mtlo_idle", {mif.hi, mif.lo}, 64'h0000_0001_0000_00AA);
        mt(1'b1, 1'b1, 32'h1234);
        check("mthi_mtlo_both", {mif.hi, mif.lo}, 64'h0000_1234_0000_1234);

        run_op("multu_mt_start", 3'd1, 32'd2, 32'd3, 64'd6, 2);

        illegal_start("illegal_110", 3'd6);
`ifdef MDU_MADD_EN
        mt(1'b1, 1'b0, 32'h0);
        mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        run_op("maddu_1x1", 3'd5, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 0);
        run_op("madd_m1x1", 3'd4, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 0);
`else
        illegal_start("maddu_disabled", 3'd5);
        illegal_start("madd_disabled", 3'd4);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Next generation of the single-cycle ALU path: width-parametrised, multi-cycle FSM with start/busy/done handshake, signed and unsigned ops.
- Sits beside the ALU. The controller stalls on busy. MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be at least 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  launch request, sampled on the rising edge
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU; 110/111 illegal
- a  input  WIDTH  multiplicand or dividend (rs)
- b  input  WIDTH  multiplier or divisor (rt)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wd  input  WIDTH  MTHI/MTLO write data
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hi  output  WIDTH  HI register (high product or remainder)
- lo  output  WIDTH  LO register (low product or quotient)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset, including mid-operation: state returns to IDLE; hi=0, lo=0, busy=0, done=0; the in-flight op is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN: on an edge with start=1 and a legal op.
  - a, b and op are latched at that edge (E0).
  - busy=1 after E0.
  - Start with an illegal op is ignored.
- RUN: exactly WIDTH iterations, one per edge (edges E1..E_WIDTH), 1 bit per cycle.
  - Multiply: shift-add on |a|, |b| into a 2*WIDTH accumulator.
  - Divide: restoring division on |a|, |b|.
  - Unsigned ops use raw operands.
- RUN -> FIX: after the final iteration.
- FIX: the edge E_(WIDTH+1) writes hi/lo, sets done=1 and busy=0, and returns to IDLE.
- Total latency: done is visible WIDTH+1 cycles after the start edge. done is high for exactly one cycle, and busy and done are never both 1.
- A start presented in the done cycle is accepted; back-to-back operation is permitted.
- start while busy=1 is ignored; no queuing.
- Signed multiply: the 2*WIDTH product is negated when a and b have opposite signs. {hi,lo} = full product.
- Signed divide:
  - Quotient is negated when signs differ; remainder takes the sign of the dividend (truncating division).
  - lo = quotient, hi = remainder.
  - MIN/-1: lo=MIN, hi=0.
- Divide by zero (DIV and DIVU): hi=a, lo=all ones; no sign fix; latency unchanged.
- hi_we/lo_we: write wd into hi/lo at the edge when busy=0 and the FSM is not in FIX. They are ignored while busy or in FIX; the FIX write wins.
  - hi_we and lo_we together in IDLE write both.
  - hi_we/lo_we in the same edge as a start: the write is applied, and the later op result overwrites it.
- hi/lo change only at reset, MTHI/MTLO, or FIX. They hold their old values throughout RUN.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 100 (MADD): {hi,lo} += signed product.
  - op 101 (MADDU): {hi,lo} += unsigned product.
  - Sum is modulo 2^(2*WIDTH). The {hi,lo} value sampled at FIX is the addend.
  - Latency is identical to MULT.
- Undefined: ops 100/101 are illegal; start is ignored, busy stays 0, and hi/lo are untouched.

Test Plan:
- Reset mid-RUN (10 cycles after MULTU start) -> next cycle busy=0, done=0, hi=0, lo=0; a fresh MULTU 6*7 then gives lo=42, hi=0.
- MULT a=0xFFFFFFFD (-3), b=5 -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 32 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=123, b=0 -> hi=123, lo=0xFFFFFFFF.
- start with op=001 during busy, plus hi_we=1 wd=0x55 mid-RUN -> both ignored; the original result lands. MTLO 0xAA in IDLE -> lo=0xAA next cycle.
- With MDU_MADD_EN and hi=0, lo=0xFFFFFFFF: MADDU 1*1 -> hi=1, lo=0. Without the macro: op=101 start -> busy stays 0, hi/lo unchanged.
